// File: rtl/weather_poll_scheduler.sv
// Weather sensor poll scheduler: sweeps four channels over a shared request/ack bus and commits one snapshot per sweep.
// Optional feature: define WPS_ACK_TIMEOUT_EN to abandon a silent channel after ACK_TIMEOUT cycles and raise sensor_fault.
module weather_poll_scheduler #(
  parameter int POLL_PERIOD = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              poll_en,
  output logic              sen_req,
  output logic [1:0]        sen_sel,
  input  logic              sen_ack,
  input  logic [7:0]        sen_data,
  output logic              thunderstorm,
  output logic [5:0]        wind,
  output logic [1:0]        visibility,
  output logic signed [7:0] temperature,
  output logic              snap_valid,
  output logic              sensor_fault,
  output logic [1:0]        wps_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] PER_LAST = 8'(POLL_PERIOD - 1);
  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ch;
  logic [7:0]  r_per_cnt;
  logic [7:0]  r_to_cnt;

  logic        r_sh_th;
  logic [5:0]  r_sh_wind;
  logic [1:0]  r_sh_vis;
  logic [7:0]  r_sh_temp;

  logic        r_th;
  logic [5:0]  r_wind;
  logic [1:0]  r_vis;
  logic [7:0]  r_temp;
  logic        r_snap_valid;

  logic        w_in_req;
  logic        w_ack;
  logic        w_timeout;
  logic        w_done;
  logic        w_per_hit;
  logic        w_to_hit;
  logic        w_commit;
  logic [5:0]  w_wind_sat;

  assign w_in_req   = (r_state == S_REQ);
  assign w_ack      = w_in_req && sen_ack;
  assign w_per_hit  = (r_per_cnt == PER_LAST);
  assign w_to_hit   = (r_to_cnt == TO_LAST);
  assign w_wind_sat = (sen_data > 8'd63) ? 6'd63 : sen_data[5:0];

`ifdef WPS_ACK_TIMEOUT_EN
  // An ack in the final allowed cycle wins over the timeout.
  assign w_timeout = w_in_req && !sen_ack && w_to_hit;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done   = w_ack || w_timeout;
  assign w_commit = w_done && (r_ch == 2'd3);

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (poll_en && w_per_hit) w_state_nxt = S_REQ;
      S_REQ:   if (w_done) w_state_nxt = (r_ch == 2'd3) ? S_IDLE : S_GAP;
      S_GAP:   w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_ch         <= 2'd0;
      r_per_cnt    <= 8'd0;
      r_to_cnt     <= 8'd0;
      r_sh_th      <= 1'b0;
      r_sh_wind    <= 6'd0;
      r_sh_vis     <= 2'd0;
      r_sh_temp    <= 8'd0;
      r_th         <= 1'b0;
      r_wind       <= 6'd0;
      r_vis        <= 2'd0;
      r_temp       <= 8'd0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= w_commit;

      if (r_state == S_IDLE && poll_en && !w_per_hit) r_per_cnt <= r_per_cnt + 8'd1;
      else                                            r_per_cnt <= 8'd0;

      // Stall counter saturates at the limit; only the timeout build acts on it.
      if (!w_in_req || w_done) r_to_cnt <= 8'd0;
      else if (!w_to_hit)      r_to_cnt <= r_to_cnt + 8'd1;

      unique case (r_state)
        S_IDLE:  r_ch <= 2'd0;
        S_GAP:   r_ch <= r_ch + 2'd1;
        default: r_ch <= r_ch;
      endcase

      if (w_ack) begin
        unique case (r_ch)
          2'd0: r_sh_th   <= sen_data[0];
          2'd1: r_sh_wind <= w_wind_sat;
          2'd2: r_sh_vis  <= sen_data[1:0];
          2'd3: r_sh_temp <= sen_data;
        endcase
      end

      // Temperature bypasses its shadow so the last capture lands in the same snapshot.
      if (w_commit) begin
        r_th   <= r_sh_th;
        r_wind <= r_sh_wind;
        r_vis  <= r_sh_vis;
        r_temp <= w_ack ? sen_data : r_sh_temp;
      end
    end
  end

`ifdef WPS_ACK_TIMEOUT_EN
  logic r_fault;

  always_ff @(posedge CLK) begin
    if (!RST)          r_fault <= 1'b0;
    else if (w_timeout) r_fault <= 1'b1;
  end

  assign sensor_fault = r_fault;
`else
  assign sensor_fault = 1'b0;
`endif

  assign sen_req      = w_in_req;
  assign sen_sel      = w_in_req ? r_ch : 2'd0;
  assign thunderstorm = r_th;
  assign wind         = r_wind;
  assign visibility   = r_vis;
  assign temperature  = r_temp;
  assign snap_valid   = r_snap_valid;
  assign wps_state    = r_state;

endmodule

// File: tb/tb_weather_poll_scheduler.sv
// Scoreboard bench for weather_poll_scheduler: a responder task acks each channel, expected snapshots are queued
// as acks are driven and popped when snap_valid fires.
module tb_weather_poll_scheduler;

  localparam int POLL_PERIOD = 16;
  localparam int ACK_TIMEOUT = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic              poll_en;
  logic              sen_req;
  logic [1:0]        sen_sel;
  logic              sen_ack;
  logic [7:0]        sen_data;
  logic              thunderstorm;
  logic [5:0]        wind;
  logic [1:0]        visibility;
  logic signed [7:0] temperature;
  logic              snap_valid;
  logic              sensor_fault;
  logic [1:0]        wps_state;

  typedef struct packed {
    logic       th;
    logic [5:0] wind;
    logic [1:0] vis;
    logic [7:0] temp;
  } snap_t;

  snap_t exp_q[$];
  snap_t m_sh;
  snap_t last_snap;
  snap_t got;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  weather_poll_scheduler #(
    .POLL_PERIOD (POLL_PERIOD),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .poll_en      (poll_en),
    .sen_req      (sen_req),
    .sen_sel      (sen_sel),
    .sen_ack      (sen_ack),
    .sen_data     (sen_data),
    .thunderstorm (thunderstorm),
    .wind         (wind),
    .visibility   (visibility),
    .temperature  (temperature),
    .snap_valid   (snap_valid),
    .sensor_fault (sensor_fault),
    .wps_state    (wps_state)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign got = {thunderstorm, wind, visibility, temperature};

  // Waits for REQ on channel ch, then acks (after delay cycles) or stays silent.
  task automatic ack_channel(input int ch, input logic [7:0] d, input int delay, input bit silent,
                             output int t_seen);
    int w;
    bit held;
    w = 0;
    while (!sen_req && w < 300) begin @(negedge CLK); w++; end
    t_seen = cyc;
    checks++;
    if (sen_req !== 1'b1) begin
      failures++;
      $display("FAIL req_wait ch=%0d sen_req=%b after %0d cycles, expected 1", ch, sen_req, w);
      return;
    end
    checks++;
    if (sen_sel !== 2'(ch)) begin
      failures++;
      $display("FAIL sen_sel got=%0d expected=%0d", sen_sel, ch);
    end
    if (silent) begin
      w = 0;
      while (sen_req && w < 300) begin w++; @(negedge CLK); end
      checks++;
      if (w != ACK_TIMEOUT) begin
        failures++;
        $display("FAIL timeout_len ch=%0d req_cycles=%0d expected=%0d", ch, w, ACK_TIMEOUT);
      end
      return;
    end
    held = 1'b1;
    repeat (delay) begin
      @(negedge CLK);
      if (sen_req !== 1'b1 || wps_state !== 2'd1) held = 1'b0;
    end
    if (delay > 0) begin
      checks++;
      if (!held) begin
        failures++;
        $display("FAIL req_hold ch=%0d request dropped while waiting, expected held for %0d cycles", ch, delay);
      end
    end
    sen_ack  = 1'b1;
    sen_data = d;
    case (ch)
      0: m_sh.th   = d[0];
      1: m_sh.wind = (d > 8'd63) ? 6'd63 : d[5:0];
      2: m_sh.vis  = d[1:0];
      default: m_sh.temp = d;
    endcase
    @(negedge CLK);
    sen_ack  = 1'b0;
    sen_data = 8'($urandom);
    if (ch < 3) begin
      checks++;
      if (wps_state !== 2'd2 || sen_req !== 1'b0) begin
        failures++;
        $display("FAIL gap ch=%0d wps_state=%0d sen_req=%b, expected 2/0", ch, wps_state, sen_req);
      end
    end
  endtask

  task automatic serve_sweep(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input int dly2, input bit silent2, input bit drop1,
                             input int exp_lat);
    logic [7:0] d [4];
    int t0, tx, w;
    snap_t e;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    t0 = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (drop1 && ch == 1) begin
        @(negedge CLK);
        checks++;
        if (wps_state !== 2'd1) begin
          failures++;
          $display("FAIL drop_req wps_state=%0d expected=1", wps_state);
        end
        poll_en = 1'b0;
      end
      ack_channel(ch, d[ch], (ch == 2) ? dly2 : 0, (ch == 2) && silent2, tx);
      if (ch == 0) t0 = tx;
    end
    exp_q.push_back(m_sh);
    w = 0;
    while (!snap_valid && w < 50) begin @(negedge CLK); w++; end
    checks++;
    if (snap_valid !== 1'b1) begin
      failures++;
      $display("FAIL snap_wait snap_valid=%b after %0d cycles, expected 1", snap_valid, w);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL snapshot got=%h expected=%h", got, e);
    end
    last_snap = e;
    if (exp_lat >= 0) begin
      checks++;
      if (cyc - t0 != exp_lat) begin
        failures++;
        $display("FAIL latency got=%0d expected=%0d", cyc - t0, exp_lat);
      end
    end
    @(negedge CLK);
    checks++;
    if (snap_valid !== 1'b0) begin
      failures++;
      $display("FAIL snap_pulse snap_valid=%b one cycle later, expected 0", snap_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; poll_en = 1'b1; sen_ack = 1'b1; sen_data = 8'hFF;
    repeat (3) @(negedge CLK);
    checks++;
    if (sen_req !== 1'b0 || sen_sel !== 2'd0 || wps_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctl req=%b sel=%0d state=%0d, expected 0/0/0", sen_req, sen_sel, wps_state);
    end
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_snap got=%h expected=0", got);
    end
    checks++;
    if (snap_valid !== 1'b0 || sensor_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags snap_valid=%b fault=%b, expected 0/0", snap_valid, sensor_fault);
    end
    sen_ack = 1'b0; poll_en = 1'b0;
    m_sh = '0; last_snap = '0;
  endtask

  task automatic test_first_req();
    int n;
    RST = 1'b1; poll_en = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!sen_req && n < 200);
    checks++;
    if (n != POLL_PERIOD) begin
      failures++;
      $display("FAIL first_req cycles=%0d expected=%0d", n, POLL_PERIOD);
    end
  endtask

  task automatic test_basic_sweep();
    test_first_req();
    serve_sweep(8'h01, 8'h0C, 8'h00, 8'h19, 0, 1'b0, 1'b0, 7);
    checks++;
    if (got !== {1'b1, 6'd12, 2'd0, 8'd25}) begin
      failures++;
      $display("FAIL basic_values got=%h expected=%h", got, {1'b1, 6'd12, 2'd0, 8'd25});
    end
  endtask

  task automatic test_saturation();
    poll_en = 1'b1;
    serve_sweep(8'h01, 8'hC8, 8'h02, 8'hD8, 0, 1'b0, 1'b0, 7);
    checks++;
    if (wind !== 6'd63 || temperature !== -8'sd40) begin
      failures++;
      $display("FAIL sat_values wind=%0d temp=%0d, expected 63/-40", wind, temperature);
    end
    serve_sweep(8'hFE, 8'h3F, 8'hFF, 8'h80, 0, 1'b0, 1'b0, 7);
    serve_sweep(8'h03, 8'h40, 8'h05, 8'h7F, 0, 1'b0, 1'b0, 7);
    serve_sweep(8'h00, 8'h3E, 8'h00, 8'h00, 0, 1'b0, 1'b0, 7);
  endtask

  task automatic test_delayed_ack();
    poll_en = 1'b1;
    serve_sweep(8'h00, 8'h05, 8'h02, 8'h10, 5, 1'b0, 1'b0, 12);
  endtask

`ifdef WPS_ACK_TIMEOUT_EN
  task automatic test_timeout();
    poll_en = 1'b1;
    checks++;
    if (sensor_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_pre sensor_fault=%b expected=0", sensor_fault);
    end
    serve_sweep(8'h01, 8'h10, 8'hAB, 8'h20, 0, 1'b1, 1'b0, -1);
    checks++;
    if (sensor_fault !== 1'b1 || visibility !== 2'd2) begin
      failures++;
      $display("FAIL timeout_result fault=%b vis=%0d, expected 1/2", sensor_fault, visibility);
    end
  endtask
`else
  task automatic test_no_fault();
    checks++;
    if (sensor_fault !== 1'b0) begin
      failures++;
      $display("FAIL no_fault sensor_fault=%b expected=0", sensor_fault);
    end
  endtask
`endif

  task automatic test_poll_drop();
    int bad;
    poll_en = 1'b1;
    serve_sweep(8'h00, 8'h21, 8'h01, 8'hF0, 0, 1'b0, 1'b1, 7);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (wps_state !== 2'd0 || sen_req !== 1'b0 || snap_valid !== 1'b0 || got !== last_snap) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL poll_drop_idle bad_cycles=%0d expected=0", bad);
    end
  endtask

  task automatic test_ack_idle();
    poll_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sen_ack = 1'b1; sen_data = 8'($urandom);
      @(negedge CLK);
      sen_ack = 1'b0;
      @(negedge CLK);
      checks++;
      if (wps_state !== 2'd0 || snap_valid !== 1'b0 || got !== last_snap) begin
        failures++;
        $display("FAIL ack_idle state=%0d snap_valid=%b got=%h expected 0/0/%h", wps_state, snap_valid, got, last_snap);
      end
    end
  endtask

  task automatic test_mid_reset();
    int t;
    int bad;
    poll_en = 1'b1;
    ack_channel(0, 8'h00, 0, 1'b0, t);
    ack_channel(1, 8'h11, 0, 1'b0, t);
    ack_channel(2, 8'h03, 0, 1'b0, t);
    checks++;
    if (wps_state !== 2'd2) begin
      failures++;
      $display("FAIL mid_gap wps_state=%0d expected=2", wps_state);
    end
    RST = 1'b0; sen_ack = 1'b1; sen_data = 8'h55;
    @(negedge CLK);
    checks++;
    if (got !== '0 || snap_valid !== 1'b0 || wps_state !== 2'd0 || sen_req !== 1'b0 || sensor_fault !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%h snap=%b state=%0d req=%b fault=%b, expected all 0",
               got, snap_valid, wps_state, sen_req, sensor_fault);
    end
    sen_ack = 1'b0; RST = 1'b1; poll_en = 1'b0;
    m_sh = '0; last_snap = '0; exp_q.delete();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      sen_ack = (i % 3 == 0); sen_data = 8'($urandom);
      @(negedge CLK);
      if (snap_valid !== 1'b0 || wps_state !== 2'd0 || got !== '0) bad++;
    end
    sen_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_reset_idle bad_cycles=%0d expected=0", bad);
    end
    test_first_req();
    serve_sweep(8'h01, 8'h3F, 8'h01, 8'hFF, 0, 1'b0, 1'b0, 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sen_data = 8'h00;
    test_reset();
    test_basic_sweep();
    test_saturation();
    test_delayed_ack();
`ifdef WPS_ACK_TIMEOUT_EN
    test_timeout();
`else
    test_no_fault();
`endif
    test_poll_drop();
    test_ack_idle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weather_poll_scheduler.md
WEATHER_POLL_SCHEDULER -- requirements
Module: weather_poll_scheduler

Interface
REQ-001 Parameter POLL_PERIOD, default 16: IDLE cycles between sweep starts while poll_en=1; legal range 2..255.
REQ-002 Parameter ACK_TIMEOUT, default 8: REQ cycles without ack before a channel is abandoned; legal range 1..255.
REQ-003 Port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 Port RST  in  1  reset; synchronous and active-low.
REQ-005 Port poll_en  in  1  enables periodic sweeps.
REQ-006 Port sen_req  out  1  shared sensor-bus request.
REQ-007 Port sen_sel  out  2  channel select: 0 thunderstorm, 1 wind, 2 visibility, 3 temperature.
REQ-008 Port sen_ack  in  1  responder acknowledge; sen_data valid in the same cycle.
REQ-009 Port sen_data  in  8  raw sensor word.
REQ-010 Ports thunderstorm (out, 1), wind (out, 6), visibility (out, 2), temperature (out, 8, signed): committed snapshot for ECSU.
REQ-011 Port snap_valid  out  1  one-cycle pulse; a new snapshot is committed.
REQ-012 Port sensor_fault  out  1  sticky flag; a channel timed out.
REQ-013 Port wps_state  out  2  FSM state: 0 IDLE, 1 REQ, 2 GAP.

Function
REQ-014 FSM states are IDLE, REQ and GAP; the channel index ch is 2 bits.
REQ-015 IDLE: the period counter increments while poll_en=1 and is held at 0 while poll_en=0; at count POLL_PERIOD-1 the FSM goes to REQ with ch=0 and the counter clears.
REQ-016 REQ: sen_req=1 and sen_sel=ch; sen_req=0 in every other state.
REQ-017 A clock edge that samples sen_ack=1 in REQ captures sen_data into the shadow register of ch.
REQ-018 After a channel-0..2 completion (ack or timeout) the FSM goes to GAP for exactly one cycle, then to REQ with ch+1.
REQ-019 Capture rules: thunderstorm=sen_data[0]; wind=min(sen_data,63), unsigned saturating; visibility=sen_data[1:0]; temperature=sen_data, taken as two's complement.
REQ-020 Completion of ch=3 loads all four outputs from the shadows, including the ch=3 capture, at that same edge; snap_valid=1 for exactly the following cycle; the FSM returns to IDLE.
REQ-021 With an ack in the first REQ cycle of every channel, snap_valid rises 7 cycles after IDLE is left (REQ,GAP,REQ,GAP,REQ,GAP,REQ).
REQ-022 Outputs change only on a commit; they hold their value between sweeps.
REQ-023 sen_ack outside REQ is ignored; no capture and no state change.
REQ-024 poll_en=0 mid-sweep does not abort: the sweep completes and commits, then the FSM waits in IDLE.
REQ-025 A sweep never re-enters REQ for a channel it has already completed.

Reset
REQ-026 RST=0 at a rising edge sets: FSM IDLE, ch=0, both counters 0, shadows 0, sen_req=0, sen_sel=0, all snapshot outputs 0, snap_valid=0, sensor_fault=0, wps_state=0.
REQ-027 Reset mid-sweep abandons the sweep with no commit; an ack in the reset cycle is discarded.
REQ-028 The first sweep after RST returns to 1 starts POLL_PERIOD cycles later when poll_en=1.

Configuration
REQ-029 Macro WPS_ACK_TIMEOUT_EN defined: REQ counts cycles without an ack.
- Reaching ACK_TIMEOUT: sensor_fault set, shadow of ch left unchanged, channel treated as complete.
- An ack sampled in the timeout cycle itself takes priority: data captured, no fault.
REQ-030 Macro WPS_ACK_TIMEOUT_EN undefined: REQ waits indefinitely for an ack; sensor_fault is tied to 0.
REQ-031 sensor_fault, once set, clears only by reset.

Verification
REQ-032 Reset, then poll_en=1; responder acks immediately with 0x01/0x0C/0x00/0x19 -> snap_valid pulse 7 cycles after leaving IDLE; outputs thunderstorm=1, wind=12, visibility=0, temperature=25.
REQ-033 Wind channel returns 0xC8 (200) -> wind=63; temperature channel returns 0xD8 -> temperature=-40.
REQ-034 WPS_ACK_TIMEOUT_EN defined, ACK_TIMEOUT=8, no ack on ch=2 -> sen_req high for 8 cycles, sensor_fault=1, visibility keeps its prior value (2), snapshot still committed.
REQ-035 poll_en dropped during the REQ of ch=1 -> sweep completes with one snap_valid, then wps_state stays 0 and sen_req stays 0 for 100 cycles.
REQ-036 RST=0 asserted during the GAP after ch=2 -> no snap_valid, all outputs 0 on the next cycle; sen_ack pulses while in IDLE cause no change.
